bus_arbiter: RTL and testbench

- Arbitrates ownership of the shared 8-bit system BUS among N_REQ tri-state drivers (register bank, data memory manager, ALU, IR/PC path).
- Issues a registered one-hot grant, inserts one turnaround cycle before the winner's output-enable, and rotates priority round-robin.
- Bounds multi-cycle (locked) ownership with a watchdog.
- Sits between the control unit's per-block enable requests and the blocks' out-enable pins, so that at most one driver is ever active on BUS.

---
 rtl/bus_arbiter.sv | 179 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Decides which tri-state block may drive the shared 8-bit BUS. Grants are
//   registered and one-hot. One dead (turnaround) cycle separates a new grant
//   from its output-enable. Priority rotates round-robin after every ownership.
//   Locked ownership is capped at MAX_HOLD drive cycles by a watchdog.
//
// Ports
//   clk           : system clock, rising edge
//   rst_n         : asynchronous active-low reset
//   req[N_REQ]    : per-requester bus request (level)
//   lock[N_REQ]   : per-requester hold, meaningful only together with req
//   clear_timeout : synchronous clear of the sticky timeout flag
//   grant[N_REQ]  : registered one-hot grant, zero when idle
//   drive_en[N_REQ]: registered one-hot output-enable, zero or equal to grant
//   owner[IDX_W]  : index of the granted requester, zero when not busy
//   busy          : a grant is asserted
//   timeout       : sticky, an ownership was cut by the watchdog
//
// Handshake: req is a level request; the requester owns the bus for every
// cycle in which its drive_en bit is high, and releases it by dropping req
// (or lock, for a single beat). There is no back-pressure on the grant.
module bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDX_W    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] lock,
    input  logic             clear_timeout,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] drive_en,
    output logic [IDX_W-1:0] owner,
    output logic             busy,
    output logic             timeout
);

    localparam int CNT_W = $clog2(MAX_HOLD) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, TURN, OWN} state_t;

    state_t           state, state_n;
    logic [N_REQ-1:0] grant_n, drive_n;
    logic [IDX_W-1:0] owner_n, ptr, ptr_n, arb_base, win;
    logic             busy_n, timeout_n, wd_cut, own_exit;
    logic [CNT_W-1:0] cnt, cnt_n;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (int'(i) == N_REQ - 1) return '0;
        return IDX_W'(int'(i) + 1);
    endfunction

    // First set bit of r, scanning upward from base and wrapping.
    function automatic logic [IDX_W-1:0] pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] base);
        logic [IDX_W-1:0] idx, w;
        logic             found;
        idx   = base;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
            idx = next_idx(idx);
        end
        return w;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        return N_REQ'(1) << i;
    endfunction

    // On an ownership exit the pointer moves past the owner at the same edge
    // as the re-arbitration, so the scan already starts from owner+1.
    assign arb_base = (state == OWN) ? next_idx(owner) : ptr;
    assign win      = pick(req, arb_base);

    always_comb begin
        state_n  = state;
        grant_n  = grant;
        drive_n  = drive_en;
        owner_n  = owner;
        busy_n   = busy;
        ptr_n    = ptr;
        cnt_n    = cnt;
        wd_cut   = 1'b0;
        own_exit = 1'b0;
        case (state)
            IDLE: begin
                drive_n = '0;
                if (|req) begin
                    grant_n = onehot(win);
                    owner_n = win;
                    busy_n  = 1'b1;
                    state_n = TURN;
                end
            end
            TURN: begin
                if (!req[owner]) begin
                    grant_n = '0;
                    owner_n = '0;
                    busy_n  = 1'b0;
                    ptr_n   = next_idx(owner);
                    state_n = IDLE;
                end else begin
                    drive_n = grant;
                    cnt_n   = '0;
                    state_n = OWN;
                end
            end
            OWN: begin
                cnt_n    = cnt + CNT_W'(1);
                own_exit = !req[owner] || !lock[owner] || (cnt == HOLD_LAST);
                // Only a cut of a still-wanted locked ownership counts as a
                // watchdog event; a natural release on the last cycle does not.
                wd_cut   = req[owner] && lock[owner] && (cnt == HOLD_LAST);
                if (own_exit) begin
                    ptr_n   = next_idx(owner);
                    drive_n = '0;
                    cnt_n   = '0;
                    if (|req) begin
                        grant_n = onehot(win);
                        owner_n = win;
                        state_n = TURN;
                    end else begin
                        grant_n = '0;
                        owner_n = '0;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                drive_n = '0;
                owner_n = '0;
                busy_n  = 1'b0;
                cnt_n   = '0;
            end
        endcase
        // Set wins over a simultaneous clear.
        timeout_n = wd_cut | (timeout & ~clear_timeout);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            drive_en <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            ptr      <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            drive_en <= drive_n;
            owner    <= owner_n;
            busy     <= busy_n;
            timeout  <= timeout_n;
            ptr      <= ptr_n;
            cnt      <= cnt_n;
        end
    end

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant));
    a_drive_subset : assert property (@(posedge clk) disable iff (!rst_n)
        (drive_en == '0) || (drive_en == grant));
    a_no_drive_on_new_grant : assert property (@(posedge clk) disable iff (!rst_n)
        ((grant != '0) && (grant != $past(grant))) |-> (drive_en == '0));

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic       clear_timeout;
    logic [3:0] grant;
    logic [3:0] drive_en;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    bus_arbiter #(.N_REQ(4), .MAX_HOLD(8), .IDX_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .lock          (lock),
        .clear_timeout (clear_timeout),
        .grant         (grant),
        .drive_en      (drive_en),
        .owner         (owner),
        .busy          (busy),
        .timeout       (timeout)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_time_limit actual=expired expected=finish");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic       clr;
        logic [3:0] g;
        logic [3:0] d;
        logic [1:0] o;
        logic       b;
        logic       t;
    } vec_t;

    vec_t tbl[$];

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] d,
                           input logic [1:0] o, input logic b, input logic t);
        chk({tag, ".grant"},    32'(grant),    32'(g));
        chk({tag, ".drive_en"}, 32'(drive_en), 32'(d));
        chk({tag, ".owner"},    32'(owner),    32'(o));
        chk({tag, ".busy"},     32'(busy),     32'(b));
        chk({tag, ".timeout"},  32'(timeout),  32'(t));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        lock = '0;
        clear_timeout = 1'b0;
        repeat (2) step();
        chk_all("reset", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] l, input logic c,
                       input logic [3:0] g, input logic [3:0] d, input logic [1:0] o,
                       input logic b, input logic t);
        vec_t v;
        v.req = r; v.lock = l; v.clr = c;
        v.g = g; v.d = d; v.o = o; v.b = b; v.t = t;
        tbl.push_back(v);
    endtask

    // Watchdog: requester 1 locked, requester 3 waiting. Eight drive cycles,
    // then timeout and a handoff to 3 after one dead cycle.
    task automatic run_watchdog(input logic race);
        do_reset();
        req  = 4'b1010;
        lock = 4'b0010;
        step();
        chk_all("wd_grant", 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk_all($sformatf("wd_drive%0d", k), 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        clear_timeout = race;
        step();
        chk_all("wd_exit", 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b1);
        clear_timeout = race;
        step();
        chk_all("wd_after", 4'b1000, 4'b1000, 2'd3, 1'b1, race ? 1'b0 : 1'b1);
        clear_timeout = 1'b0;
    endtask

    // ---------------- scoreboard / sequence ----------------
    initial begin
        logic seen;
        rst_n = 1'b0;
        req = '0;
        lock = '0;
        clear_timeout = 1'b0;

        // single beat from IDLE, then contention with ptr=3
        add(4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 2'd2, 1, 0);
        add(4'b0100, 4'b0000, 0, 4'b0100, 4'b0100, 2'd2, 1, 0);
        add(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);
        add(4'b1001, 4'b0000, 0, 4'b1000, 4'b0000, 2'd3, 1, 0);
        add(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);
        // round robin with all requesting, ptr back at 0
        add(4'b1111, 4'b0000, 0, 4'b0001, 4'b0000, 2'd0, 1, 0);
        add(4'b1111, 4'b0000, 0, 4'b0001, 4'b0001, 2'd0, 1, 0);
        add(4'b1111, 4'b0000, 0, 4'b0010, 4'b0000, 2'd1, 1, 0);
        add(4'b1111, 4'b0000, 0, 4'b0010, 4'b0010, 2'd1, 1, 0);
        add(4'b1111, 4'b0000, 0, 4'b0100, 4'b0000, 2'd2, 1, 0);
        add(4'b1111, 4'b0000, 0, 4'b0100, 4'b0100, 2'd2, 1, 0);
        add(4'b1111, 4'b0000, 0, 4'b1000, 4'b0000, 2'd3, 1, 0);
        add(4'b1111, 4'b0000, 0, 4'b1000, 4'b1000, 2'd3, 1, 0);
        add(4'b1111, 4'b0000, 0, 4'b0001, 4'b0000, 2'd0, 1, 0);
        add(4'b1111, 4'b0000, 0, 4'b0001, 4'b0001, 2'd0, 1, 0);
        add(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);
        // withdraw in TURN: ptr ends at 1, then 2
        add(4'b0001, 4'b0000, 0, 4'b0001, 4'b0000, 2'd0, 1, 0);
        add(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);
        add(4'b1111, 4'b0000, 0, 4'b0010, 4'b0000, 2'd1, 1, 0);
        add(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);
        add(4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 2'd2, 1, 0);
        // lock without req is ignored; clear with nothing set keeps 0
        add(4'b0000, 4'b1111, 1, 4'b0000, 4'b0000, 2'd0, 0, 0);
        add(4'b0000, 4'b1111, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);

        do_reset();
        foreach (tbl[i]) begin
            req           = tbl[i].req;
            lock          = tbl[i].lock;
            clear_timeout = tbl[i].clr;
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].g, tbl[i].d, tbl[i].o, tbl[i].b, tbl[i].t);
        end

        run_watchdog(1'b0);

        // reset mid-OWN with requester 1 driving and timeout still set
        req  = 4'b0010;
        lock = 4'b0010;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            if (drive_en == 4'b0010) seen = 1'b1;
        end
        chk("rst_own_reached", 32'(seen), 32'd1);
        chk("rst_own_timeout_before", 32'(timeout), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk_all("rst_async", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        req  = 4'b0100;
        lock = 4'b0000;
        step();
        chk_all("rst_regrant", 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0);

        run_watchdog(1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
